// File: rtl/music_box_pkg.sv
// Shared music-box definitions: sequencer state encoding and the generator field widths
// used by the song sequencer and the SignalGenerator bank.
package music_box_pkg;

   localparam int CHANNELS_DEF = 3;
   localparam int FREQ_W_DEF   = 14;
   localparam int AMP_W_DEF    = 8;
   localparam int ROM_W        = 16;

   typedef logic [FREQ_W_DEF-1:0] freq_t;
   typedef logic [AMP_W_DEF-1:0]  amp_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_WAIT   = 3'd2,
      S_CAPT   = 3'd3,
      S_COMMIT = 3'd4,
      S_PLAY   = 3'd5,
      S_DONE   = 3'd6
   } seq_state_e;

   // One frequency word and one amplitude word per channel.
   function automatic int words_per_frame(input int channels);
      return 2 * channels;
   endfunction

endpackage

// File: rtl/song_frame_sequencer_step_timer.sv
// Step timer for the song sequencer: down-counts tick_1Khz pulses while the sequencer is busy
// and flags the tick that ends a step.
module song_step_timer #(
   parameter int STEP_MS = 50
) (
   input  logic clock_50Mhz,
   input  logic reset_n,
   input  logic tick_i,
   input  logic en_i,
   input  logic clear_i,
   output logic step_done_o
);

   localparam int CNT_W = $clog2(STEP_MS + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_MS);

   logic [CNT_W-1:0] left_q;
   logic [CNT_W-1:0] left_d;

   assign step_done_o = en_i && tick_i && !clear_i && (left_q == CNT_W'(1));

   // The tick that finishes a step reloads the counter, so the next step starts clean.
   always_comb begin
      left_d = left_q;
      if (clear_i) begin
         left_d = RELOAD;
      end else if (en_i && tick_i) begin
         left_d = step_done_o ? RELOAD : left_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock_50Mhz) begin
      if (!reset_n) begin
         left_q <= RELOAD;
      end else begin
         left_q <= left_d;
      end
   end

endmodule

// File: rtl/song_frame_sequencer.sv
// Song frame sequencer: fetches one frame per step from the song ROM and commits it atomically
// to the generator bank. Define SONG_SEQ_LOOP_EN to loop the song instead of finishing.
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | rom_addr presented for the current word
// WAIT   | ROM latency countdown
// CAPT   | rom_data captured into the word's shadow register
// COMMIT | full frame moved to ch_*, frame_strobe high
// PLAY   | counting out the step
// DONE   | one-cycle completion, amplitudes silenced
module song_frame_sequencer
   import music_box_pkg::*;
#(
   parameter int CHANNELS    = CHANNELS_DEF,
   parameter int FRAME_COUNT = 184,
   parameter int STEP_MS     = 50,
   parameter int ROM_LATENCY = 1,
   parameter int ADDR_W      = 16,
   parameter int FREQ_W      = FREQ_W_DEF,
   parameter int AMP_W       = AMP_W_DEF
) (
   input  logic                       clock_50Mhz,
   input  logic                       reset_n,
   input  logic                       tick_1Khz,
   input  logic                       start,
   input  logic                       abort,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [ROM_W-1:0]           rom_data,
   output logic [CHANNELS*FREQ_W-1:0] ch_frequency,
   output logic [CHANNELS*AMP_W-1:0]  ch_amplitude,
   output logic                       frame_strobe,
   output logic [ADDR_W-1:0]          current_frame,
   output logic                       busy,
   output logic                       stateComplete
);

   localparam int WORDS   = words_per_frame(CHANNELS);
   localparam int WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int LAT_W   = 2;
   localparam int FIELD_W = (FREQ_W > AMP_W) ? FREQ_W : AMP_W;
   localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] LAST_FRAME = ADDR_W'(FRAME_COUNT - 1);
   localparam longint unsigned   SONG_WORDS = longint'(FRAME_COUNT) * longint'(WORDS);
   localparam longint unsigned   ADDR_SPAN  = 64'd1 << ADDR_W;

   if (SONG_WORDS > ADDR_SPAN) begin : g_span_chk
      $error("song_frame_sequencer: FRAME_COUNT*2*CHANNELS exceeds 2**ADDR_W");
   end
   if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_lat_chk
      $error("song_frame_sequencer: ROM_LATENCY must be 1..4");
   end

   seq_state_e                          state_q, state_d;
   logic [ADDR_W-1:0]                   frame_q, frame_d;
   logic [WORD_W-1:0]                   word_q, word_d;
   logic [LAT_W-1:0]                    lat_q, lat_d;
   logic [ADDR_W-1:0]                   cur_frame_q, cur_frame_d;
   logic [WORDS-1:0][FIELD_W-1:0]       shadow_q, shadow_n;
   logic [CHANNELS*FREQ_W-1:0]          freq_q, freq_d;
   logic [CHANNELS*AMP_W-1:0]           amp_q, amp_d;
   logic                                step_clr;
   logic                                step_done;
   logic                                unused_bits;

   song_step_timer #(
      .STEP_MS (STEP_MS)
   ) u_step_timer (
      .clock_50Mhz (clock_50Mhz),
      .reset_n     (reset_n),
      .tick_i      (tick_1Khz),
      .en_i        (busy),
      .clear_i     (step_clr),
      .step_done_o (step_done)
   );

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      word_d   = word_q;
      lat_d    = lat_q;
      step_clr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d  = S_ADDR;
               frame_d  = '0;
               word_d   = '0;
               step_clr = 1'b1;
            end
         end
         S_ADDR: begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(ROM_LATENCY - 1);
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               state_d = S_CAPT;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_CAPT: begin
            if (word_q == LAST_WORD) begin
               state_d = S_COMMIT;
            end else begin
               word_d  = word_q + WORD_W'(1);
               state_d = S_ADDR;
            end
         end
         S_COMMIT: begin
            state_d = S_PLAY;
         end
         S_PLAY: begin
            if (step_done) begin
               word_d = '0;
               if (frame_q == LAST_FRAME) begin
`ifdef SONG_SEQ_LOOP_EN
                  frame_d = '0;
                  state_d = S_ADDR;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  frame_d = frame_q + ADDR_W'(1);
                  state_d = S_ADDR;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            frame_d = '0;
            word_d  = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort && state_q != S_IDLE && state_q != S_DONE) begin
         state_d = S_DONE;
      end
   end

   // The last word bypasses its shadow so the frame lands on ch_* in the COMMIT cycle itself.
   always_comb begin
      shadow_n    = shadow_q;
      freq_d      = freq_q;
      amp_d       = amp_q;
      cur_frame_d = cur_frame_q;
      if (state_q == S_CAPT) begin
         shadow_n[word_q] = rom_data[FIELD_W-1:0];
      end
      if (state_q == S_CAPT && state_d == S_COMMIT) begin
         for (int c = 0; c < CHANNELS; c++) begin
            freq_d[c*FREQ_W +: FREQ_W] = shadow_n[2*c][FREQ_W-1:0];
            amp_d[c*AMP_W +: AMP_W]    = shadow_n[2*c+1][AMP_W-1:0];
         end
         cur_frame_d = frame_q;
      end
      if (state_d == S_DONE) begin
         amp_d = '0;
      end
   end

   always_ff @(posedge clock_50Mhz) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         frame_q     <= '0;
         word_q      <= '0;
         lat_q       <= '0;
         cur_frame_q <= '0;
         shadow_q    <= '0;
         freq_q      <= '0;
         amp_q       <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         word_q      <= word_d;
         lat_q       <= lat_d;
         cur_frame_q <= cur_frame_d;
         shadow_q    <= shadow_n;
         freq_q      <= freq_d;
         amp_q       <= amp_d;
      end
   end

   assign rom_addr      = frame_q * ADDR_W'(WORDS) + ADDR_W'(word_q);
   assign ch_frequency  = freq_q;
   assign ch_amplitude  = amp_q;
   assign current_frame = cur_frame_q;
   assign frame_strobe  = (state_q == S_COMMIT);
   assign stateComplete = (state_q == S_DONE);
   assign busy          = (state_q != S_IDLE);
   assign unused_bits   = ^{rom_data, shadow_q};

endmodule

// File: tb/tb_song_frame_sequencer.sv
// Scoreboard bench for song_frame_sequencer: ROM returns its address, 3 frames of 2 ms each.
module tb_song_frame_sequencer;

   localparam int CH  = 3;
   localparam int FC  = 3;
   localparam int SMS = 2;
   localparam int LAT = 1;
   localparam int AW  = 16;
   localparam int FW  = 14;
   localparam int MW  = 8;
   localparam int FETCH_CYC = 2 * CH * (LAT + 2) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tick = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [AW-1:0]     rom_addr;
   logic [15:0]       rom_data = '0;
   logic [CH*FW-1:0]  ch_freq;
   logic [CH*MW-1:0]  ch_amp;
   logic              strobe;
   logic [AW-1:0]     cur_frame;
   logic              busy;
   logic              done;

   typedef struct {
      bit               is_end;
      int               frame;
      logic [CH*FW-1:0] freq;
      logic [CH*MW-1:0] amp;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   song_frame_sequencer #(
      .CHANNELS    (CH),
      .FRAME_COUNT (FC),
      .STEP_MS     (SMS),
      .ROM_LATENCY (LAT),
      .ADDR_W      (AW),
      .FREQ_W      (FW),
      .AMP_W       (MW)
   ) dut (
      .clock_50Mhz   (clk),
      .reset_n       (rst_n),
      .tick_1Khz     (tick),
      .start         (start),
      .abort         (abort),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .ch_frequency  (ch_freq),
      .ch_amplitude  (ch_amp),
      .frame_strobe  (strobe),
      .current_frame (cur_frame),
      .busy          (busy),
      .stateComplete (done)
   );

   always #10 clk = ~clk;

   always @(posedge clk) rom_data <= rom_addr;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [CH*FW-1:0] efreq(input int f);
      logic [CH*FW-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) r[c*FW +: FW] = FW'(2 * CH * f + 2 * c);
      return r;
   endfunction

   function automatic logic [CH*MW-1:0] eamp(input int f);
      logic [CH*MW-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) r[c*MW +: MW] = MW'(2 * CH * f + 2 * c + 1);
      return r;
   endfunction

   function automatic exp_t commit_rec(input int f);
      exp_t e;
      e.is_end = 1'b0;
      e.frame  = f;
      e.freq   = efreq(f);
      e.amp    = eamp(f);
      return e;
   endfunction

   function automatic exp_t end_rec(input int last_f);
      exp_t e;
      e.is_end = 1'b1;
      e.frame  = last_f;
      e.freq   = efreq(last_f);
      e.amp    = '0;
      return e;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && (strobe || done)) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_event", {62'd0, strobe, done}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("ev_done", done, e.is_end);
            check_eq("ev_strobe", strobe, !e.is_end);
            check_eq(e.is_end ? "end_freq" : "commit_freq", ch_freq, e.freq);
            check_eq(e.is_end ? "end_amp" : "commit_amp", ch_amp, e.amp);
            if (!e.is_end) check_eq("commit_frame", cur_frame, 64'(e.frame));
            else check_eq("busy_in_done", busy, 1'b1);
         end
      end
   end

   task automatic pulse_tick();
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_abort();
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!strobe && n < 200);
      if (n >= 200) check_eq("strobe_timeout", strobe, 1'b1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      if (n >= 200) check_eq("done_timeout", done, 1'b1);
   endtask

   task automatic start_song();
      int n;
      exp_q.push_back(commit_rec(0));
      pulse_start();
      check_eq("start_busy", busy, 1'b1);
      check_eq("start_addr", rom_addr, 0);
      wait_strobe(n);
      check_eq("lat_f0", n, FETCH_CYC);
   endtask

   task automatic next_step(input int f);
      int n;
      exp_q.push_back(commit_rec(f));
      pulse_tick();
      pulse_tick();
      check_eq("step_addr", rom_addr, 2 * CH * f);
      wait_strobe(n);
      check_eq("lat_step", n, FETCH_CYC);
   endtask

   task automatic after_end_checks();
      @(negedge clk);
      check_eq("done_one_cycle", done, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_amp", ch_amp, 0);
   endtask

   task automatic finish_song();
      int n;
      exp_q.push_back(end_rec(FC - 1));
      pulse_tick();
      pulse_tick();
      wait_done(n);
      check_eq("lat_done", n, 1);
      after_end_checks();
      check_eq("held_freq", ch_freq, efreq(FC - 1));
   endtask

   task automatic abort_now(input int last_f);
      int n;
      exp_q.push_back(end_rec(last_f));
      pulse_abort();
      wait_done(n);
      check_eq("lat_abort", n, 1);
      after_end_checks();
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_addr", rom_addr, 0);
      check_eq("rst_freq", ch_freq, 0);
      check_eq("rst_amp", ch_amp, 0);
      check_eq("rst_frame", cur_frame, 0);
      check_eq("rst_flags", {strobe, done, busy}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Full song with an explicit address walk over frame 0.
      exp_q.push_back(commit_rec(0));
      pulse_start();
      for (int k = 1; k <= FETCH_CYC; k++) begin
         @(negedge clk);
         if (k < FETCH_CYC && (k - 1) % (LAT + 2) == 0)
            check_eq($sformatf("walk_%0d", k), rom_addr, (k - 1) / (LAT + 2));
      end
      check_eq("strobe_f0", strobe, 1'b1);
      @(negedge clk);
      check_eq("strobe_one_cycle", strobe, 1'b0);
      next_step(1);
      next_step(2);
`ifdef SONG_SEQ_LOOP_EN
      for (int i = 3; i < 10; i++) next_step(i % FC);
      abort_now(9 % FC);
`else
      finish_song();
`endif

      // Abort while frame 1's first word is waiting on the ROM.
      start_song();
      pulse_tick();
      pulse_tick();
      exp_q.push_back(end_rec(0));
      @(posedge clk); #1;
      check_eq("wait_addr_f1", rom_addr, 2 * CH);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      wait_done(n);
      check_eq("lat_abort_wait", n, 1);
      after_end_checks();
      check_eq("abort_freq_kept", ch_freq, efreq(0));

      // start and abort together in IDLE: abort wins.
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      repeat (25) @(negedge clk);
      check_eq("idle_start_abort", busy, 1'b0);

      // start during PLAY is ignored.
      start_song();
      pulse_start();
      next_step(1);
      next_step(2);
`ifdef SONG_SEQ_LOOP_EN
      abort_now(2);
`else
      finish_song();
`endif

      // Reset in the middle of the first CAPT.
      pulse_start();
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("mid_rst_addr", rom_addr, 0);
      check_eq("mid_rst_freq", ch_freq, 0);
      check_eq("mid_rst_amp", ch_amp, 0);
      check_eq("mid_rst_frame", cur_frame, 0);
      check_eq("mid_rst_flags", {strobe, done, busy}, 0);
      rst_n = 1'b1;
      start_song();
      abort_now(0);

      check_eq("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

endmodule
